// File: rtl/vend_sequencer.sv
// Coffee vending sequencer: it keeps the coin credit, accepts drink selections
// and change requests while idle, and steps through the valve sequence of the
// chosen recipe. Every output comes straight from a register.
module vend_sequencer #(
  parameter int PRICE_BLACK = 2,
  parameter int PRICE_CREAM = 3,
  parameter int PRICE_SUGAR = 4,
  parameter int STEP_TICKS  = 100,
  parameter int MONEY_MAX   = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Input_Money,
  input  logic       Req_Change,
  input  logic       Click_Black,
  input  logic       Click_Cream,
  input  logic       Click_Cream_Sugar,
  output logic [4:0] Money,
  output logic       Change,
  output logic       Coffee,
  output logic       Water,
  output logic       Cream,
  output logic       Sugar,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_COFFEE, S_CREAM, S_SUGAR, S_WATER, S_CHANGE
  } state_t;

  typedef enum logic [1:0] {R_BLACK, R_CREAM, R_SUGAR} recipe_t;

  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
  localparam logic [4:0] MAX_C = 5'(MONEY_MAX);

  state_t            state;
  recipe_t           recipe;
  logic [STEP_W-1:0] step;
  logic [4:0]        credit;

  logic [4:0] credit_inc;   // credit plus one coin, saturated
  logic [4:0] coin_credit;  // credit after this cycle's coin, if any
  logic [4:0] buy_credit;   // credit after paying the selection plus any coin
  logic [4:0] sel_price;
  recipe_t    sel_recipe;
  logic       sel_any;

  // Credit arithmetic and selection decode; the highest-priority click wins.
  always_comb begin
    credit_inc  = (credit >= MAX_C) ? MAX_C : credit + 5'd1;
    coin_credit = Input_Money ? credit_inc : credit;
    sel_any     = 1'b1;
    sel_price   = 5'(PRICE_BLACK);
    sel_recipe  = R_BLACK;
    if (Click_Cream_Sugar) begin
      sel_price  = 5'(PRICE_SUGAR);
      sel_recipe = R_SUGAR;
    end else if (Click_Cream) begin
      sel_price  = 5'(PRICE_CREAM);
      sel_recipe = R_CREAM;
    end else if (!Click_Black) begin
      sel_any = 1'b0;
    end
    // Affordability is judged on the pre-coin credit; the coin lands afterwards.
    buy_credit = credit - sel_price;
    if (Input_Money && buy_credit < MAX_C) buy_credit = buy_credit + 5'd1;
  end

  assign Money = credit;

  // Main sequencer: state, credit, step counter and registered valve/status outputs.
  // NOTE: every register here uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      recipe <= R_BLACK;
      step   <= '0;
      credit <= '0;
      Change <= 1'b0;
      Coffee <= 1'b0;
      Water  <= 1'b0;
      Cream  <= 1'b0;
      Sugar  <= 1'b0;
      Busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Req_Change) begin
            // A change request with no credit is dropped; a coin still counts.
            if (credit != 5'd0) begin
              state  <= S_CHANGE;
              Change <= 1'b1;
              Busy   <= 1'b1;
              credit <= coin_credit - 5'd1;
            end else begin
              credit <= coin_credit;
            end
          end else if (sel_any && credit >= sel_price) begin
            state  <= S_COFFEE;
            recipe <= sel_recipe;
            step   <= '0;
            credit <= buy_credit;
            Coffee <= 1'b1;
            Busy   <= 1'b1;
          end else begin
            credit <= coin_credit;
          end
        end

        S_COFFEE, S_CREAM, S_SUGAR, S_WATER: begin
          credit <= coin_credit;
          if (step != STEP_LAST) begin
            step <= step + STEP_W'(1);
          end else begin
            step   <= '0;
            Coffee <= 1'b0;
            Cream  <= 1'b0;
            Sugar  <= 1'b0;
            Water  <= 1'b0;
            case (state)
              S_COFFEE: begin
                if (recipe == R_BLACK) begin
                  state <= S_WATER;
                  Water <= 1'b1;
                end else begin
                  state <= S_CREAM;
                  Cream <= 1'b1;
                end
              end
              S_CREAM: begin
                if (recipe == R_SUGAR) begin
                  state <= S_SUGAR;
                  Sugar <= 1'b1;
                end else begin
                  state <= S_WATER;
                  Water <= 1'b1;
                end
              end
              S_SUGAR: begin
                state <= S_WATER;
                Water <= 1'b1;
              end
              default: begin
                state <= S_IDLE;
                Busy  <= 1'b0;
              end
            endcase
          end
        end

        S_CHANGE: begin
          // Change doubles as the phase bit: high cycle pays a coin, low cycle rests.
          if (Change) begin
            Change <= 1'b0;
          end else if (credit == 5'd0) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end else begin
            Change <= 1'b1;
            credit <= credit - 5'd1;
          end
        end

        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 SHALL have parameter PRICE_BLACK, default 2, price of black coffee in coin units.
REQ-002 SHALL have parameter PRICE_CREAM, default 3, price of coffee with cream.
REQ-003 SHALL have parameter PRICE_SUGAR, default 4, price of coffee with cream and sugar.
REQ-004 SHALL have parameter STEP_TICKS, default 100, cycles per dispense step (1 s at the 100 Hz system tick).
REQ-005 SHALL have parameter MONEY_MAX, default 15, credit saturation value.
REQ-006 SHALL have port CLK, input, 1, the single clock, the 100 Hz divided clock in the coffee machine top level.
REQ-007 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port Input_Money, input, 1, one-cycle pulse per coin inserted, already edge-detected.
REQ-009 SHALL have port Req_Change, input, 1, one-cycle pulse requesting return of all credit.
REQ-010 SHALL have ports Click_Black, Click_Cream and Click_Cream_Sugar, each input, 1, one-cycle selection pulses.
REQ-011 SHALL have port Money, output, 5, current credit in coin units; it drives the 7-segment decoder.
REQ-012 SHALL have port Change, output, 1, one-cycle pulse per coin returned.
REQ-013 SHALL have ports Coffee, Water, Cream and Sugar, each output, 1, valve enables, high for the whole dispense step.
REQ-014 SHALL have port Busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement an FSM with the states IDLE, COFFEE, CREAM, SUGAR, WATER and CHANGE.
REQ-016 SHALL hold credit in a 5-bit register.
- Each accepted Input_Money adds 1.
- Credit saturates at MONEY_MAX; excess coins are lost.
- Credit never wraps below 0.
REQ-017 SHALL accept Input_Money in IDLE, COFFEE, CREAM, SUGAR and WATER, and SHALL ignore it in CHANGE.
REQ-018 SHALL accept selections in IDLE only, with this priority:
- Req_Change, then Click_Cream_Sugar, then Click_Cream, then Click_Black.
- All lower-priority pulses in the same cycle are discarded.
REQ-019 SHALL, for a selection in IDLE with credit >= price, on the next edge:
- subtract the price from credit;
- enter COFFEE.
REQ-020 SHALL discard a selection with credit < price; the FSM stays in IDLE and credit is unchanged.
REQ-021 SHALL, on a coin and a selection in the same IDLE cycle:
- check affordability against the pre-coin credit;
- set credit_next = credit - price + 1 (saturating).
REQ-022 SHALL keep each dispense state for exactly STEP_TICKS cycles, using a step counter cleared on every state entry.
REQ-023 SHALL follow these dispense sequences:
- black: COFFEE, WATER, IDLE.
- cream: COFFEE, CREAM, WATER, IDLE.
- cream+sugar: COFFEE, CREAM, SUGAR, WATER, IDLE.
The selected recipe SHALL be latched at acceptance.
REQ-024 SHALL assert exactly one valve output per dispense state (COFFEE→Coffee, CREAM→Cream, SUGAR→Sugar, WATER→Water) as a registered output, and none in IDLE or CHANGE.
REQ-025 SHALL handle Req_Change in IDLE as follows:
- credit 0: ignored.
- credit > 0: enter CHANGE.
REQ-026 SHALL, in CHANGE:
- pulse Change high for one cycle, then low for one cycle, per coin;
- decrement credit by 1 on each high cycle;
- return to IDLE in the cycle after credit reaches 0.
N coins SHALL take 2N cycles.
REQ-027 SHALL ignore Req_Change and all selections while Busy is high; they are not queued.
REQ-028 SHALL produce Money and all control outputs from registers, with no combinational path from input to output.

Reset
REQ-029 SHALL, while RST is high, asynchronously force:
- FSM = IDLE;
- credit = 0;
- step counter = 0;
- latched recipe = black;
- Money = 0, Change = 0, Coffee = Water = Cream = Sugar = 0, Busy = 0.
REQ-030 SHALL abort any dispense or change in progress on reset; credit is lost.
REQ-031 SHALL act on the first input pulse in the first rising CLK edge after RST is deasserted.

Verification
REQ-032 SHALL pass: 3 coins, then Click_Black → Money 3→1; Busy 1; Coffee high 100 cycles, then Water high 100 cycles; Busy 0; Money 1.
REQ-033 SHALL pass: Money 2, Click_Cream_Sugar → ignored; Money 2; Busy 0; no valve output.
REQ-034 SHALL pass: Money 15, 2 more coins → Money 15; then Req_Change → 15 Change pulses over 30 cycles; Money 0; IDLE.
REQ-035 SHALL pass: Money 4, Click_Cream, Click_Black and Input_Money in the same cycle → cream recipe; Money 2; sequence Coffee, Cream, Water.
REQ-036 SHALL pass: coin during the WATER step → Money +1, sequence timing unchanged; Req_Change during COFFEE → ignored.
REQ-037 SHALL pass: RST pulse mid-CREAM step → all outputs 0 immediately; Money 0; next Click_Black with 0 credit ignored.
